// File: rtl/masked_sbox_scheduler.sv
// Round-robin scheduler sharing one pipelined masked AES S-box between the
// SubBytes datapath (port A) and the key-schedule SubWord path (port B).
// A byte is issued only together with a fresh randomness set, and a tag shift
// register follows each byte through the S-box so that its result returns
// with the correct owner and byte index.
module masked_sbox_scheduler #(
    parameter int SHARES   = 2,
    parameter int SBOX_LAT = 4
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRI,
    input  logic                  AValidxSI,
    output logic                  AReadyxSO,
    input  logic [3:0]            AIdxDI,
    input  logic [8*SHARES-1:0]   ADataxDI,
    input  logic                  BValidxSI,
    output logic                  BReadyxSO,
    input  logic [1:0]            BIdxDI,
    input  logic [8*SHARES-1:0]   BDataxDI,
    input  logic                  RandValidxSI,
    output logic                  RandReadyxSO,
    output logic [8*SHARES-1:0]   SboxInxDO,
    input  logic [8*SHARES-1:0]   SboxOutxDI,
    output logic                  ResValidxSO,
    output logic                  ResOwnerxSO,
    output logic [3:0]            ResIdxDO,
    output logic [8*SHARES-1:0]   ResDataxDO,
    output logic                  BusyxSO,
    output logic [15:0]           IssueCntxDO
);

    localparam int W = 8 * SHARES;

    logic                   issue;
    logic                   grantB;
    logic                   bothValid;
    logic [3:0]             idxSel;
    logic                   rrPtr_q, rrPtr_d;
    logic [W-1:0]           sboxIn_q, sboxIn_d;
    logic [15:0]            issueCnt_q, issueCnt_d;
    logic [SBOX_LAT:0]      tagValid_q, tagValid_d;
    logic [SBOX_LAT:0]      tagOwner_q, tagOwner_d;
    logic [SBOX_LAT:0][3:0] tagIdx_q, tagIdx_d;

    // Arbitration: a lone requester always wins; under contention the
    // round-robin pointer (0 = A, 1 = B) decides. Nothing issues in reset.
    always_comb begin
        bothValid = AValidxSI & BValidxSI;
        grantB    = BValidxSI & (~AValidxSI | rrPtr_q);
        issue     = RandValidxSI & (AValidxSI | BValidxSI) & ~RstxRI;
        idxSel    = grantB ? {2'b00, BIdxDI} : AIdxDI;
    end

    assign AReadyxSO    = issue & ~grantB;
    assign BReadyxSO    = issue & grantB;
    assign RandReadyxSO = issue;

    // Next-state logic: zero the S-box input on idle cycles so stale shares
    // are never re-presented, and push a fresh tag into the pipeline every cycle.
    always_comb begin
        rrPtr_d    = rrPtr_q ^ (issue & bothValid);
        sboxIn_d   = '0;
        if (issue) begin
            sboxIn_d = grantB ? BDataxDI : ADataxDI;
        end
        issueCnt_d = issueCnt_q + {15'd0, issue};
        tagValid_d = {tagValid_q[SBOX_LAT-1:0], issue};
        tagOwner_d = {tagOwner_q[SBOX_LAT-1:0], grantB};
        tagIdx_d   = {tagIdx_q[SBOX_LAT-1:0], idxSel};
    end

    // State registers; the tag pipeline cannot stall because the S-box cannot.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            rrPtr_q    <= 1'b0;
            sboxIn_q   <= '0;
            issueCnt_q <= '0;
            tagValid_q <= '0;
            tagOwner_q <= '0;
            tagIdx_q   <= '0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            sboxIn_q   <= sboxIn_d;
            issueCnt_q <= issueCnt_d;
            tagValid_q <= tagValid_d;
            tagOwner_q <= tagOwner_d;
            tagIdx_q   <= tagIdx_d;
        end
    end

    assign SboxInxDO   = sboxIn_q;
    assign ResValidxSO = tagValid_q[SBOX_LAT];
    assign ResOwnerxSO = tagOwner_q[SBOX_LAT];
    assign ResIdxDO    = tagIdx_q[SBOX_LAT];
    assign ResDataxDO  = SboxOutxDI;
    assign BusyxSO     = |tagValid_q;
    assign IssueCntxDO = issueCnt_q;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Scoreboard bench for masked_sbox_scheduler with a behavioural 4-cycle
// masked S-box model driving SboxOutxDI.
module tb_masked_sbox_scheduler;

    logic        clk;
    logic        rst;
    logic        aValid, bValid, randValid;
    logic [3:0]  aIdx;
    logic [1:0]  bIdx;
    logic [15:0] aData, bData;
    logic        aReady, bReady, randReady;
    logic [15:0] sboxIn, sboxOut, resData;
    logic        resValid, resOwner, busy;
    logic [3:0]  resIdx;
    logic [15:0] issueCnt;

    int          testsRun  = 0;
    int          failCount = 0;
    int          cyc       = 0;
    logic        monitorEn = 1'b1;
    logic [15:0] expCnt    = 16'd0;

    typedef struct {
        logic       owner;
        logic [3:0] idx;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        monE;

    masked_sbox_scheduler #(.SHARES(2), .SBOX_LAT(4)) dut (
        .ClkxCI       (clk),
        .RstxRI       (rst),
        .AValidxSI    (aValid),
        .AReadyxSO    (aReady),
        .AIdxDI       (aIdx),
        .ADataxDI     (aData),
        .BValidxSI    (bValid),
        .BReadyxSO    (bReady),
        .BIdxDI       (bIdx),
        .BDataxDI     (bData),
        .RandValidxSI (randValid),
        .RandReadyxSO (randReady),
        .SboxInxDO    (sboxIn),
        .SboxOutxDI   (sboxOut),
        .ResValidxSO  (resValid),
        .ResOwnerxSO  (resOwner),
        .ResIdxDO     (resIdx),
        .ResDataxDO   (resData),
        .BusyxSO      (busy),
        .IssueCntxDO  (issueCnt)
    );

    // Free-running clock and a cycle counter used to verify result latency.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // AES S-box entries for the bytes this bench uses.
    function automatic logic [7:0] sboxFn(input logic [7:0] x);
        case (x)
            8'h00: sboxFn = 8'h63;  8'h01: sboxFn = 8'h7c;
            8'h02: sboxFn = 8'h77;  8'h03: sboxFn = 8'h7b;
            8'h04: sboxFn = 8'hf2;  8'h05: sboxFn = 8'h6b;
            8'h06: sboxFn = 8'h6f;  8'h07: sboxFn = 8'hc5;
            8'h08: sboxFn = 8'h30;  8'h09: sboxFn = 8'h01;
            8'h0a: sboxFn = 8'h67;  8'h0b: sboxFn = 8'h2b;
            8'h0c: sboxFn = 8'hfe;  8'h0d: sboxFn = 8'hd7;
            8'h0e: sboxFn = 8'hab;  8'h0f: sboxFn = 8'h76;
            8'h10: sboxFn = 8'hca;  8'h20: sboxFn = 8'hb7;
            8'h53: sboxFn = 8'hed;  8'hff: sboxFn = 8'h16;
            default: sboxFn = 8'h00;
        endcase
    endfunction

    // Masked S-box model: four register stages behind the registered input,
    // output remasked with a mask derived from the incoming share.
    logic [15:0] pipe [4];
    logic [7:0]  mdlX, mdlM;

    always @(posedge clk) begin
        pipe[0] <= sboxIn;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end

    always_comb begin
        mdlX    = pipe[3][7:0] ^ pipe[3][15:8];
        mdlM    = pipe[3][15:8] ^ 8'h3c;
        sboxOut = {mdlM, sboxFn(mdlX) ^ mdlM};
    end

    // Single comparison point that feeds the pass/fail counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (monitorEn && resValid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedResult", {28'd0, resIdx}, 32'hffff_ffff);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("resOwner", {31'd0, resOwner}, {31'd0, monE.owner});
                checkOutput("resIdx", {28'd0, resIdx}, {28'd0, monE.idx});
                checkOutput("resData", {24'd0, resData[7:0] ^ resData[15:8]}, {24'd0, monE.data});
                checkOutput("resCycle", cyc, monE.due);
            end
        end
    end

    // One cycle of stimulus with the expected grant and expected S-box results.
    task automatic applyStimulus(input logic aV, input logic [3:0] aI,
                                 input logic [7:0] aX, input logic [7:0] aY,
                                 input logic bV, input logic [1:0] bI,
                                 input logic [7:0] bX, input logic [7:0] bY,
                                 input logic rV, input logic expA, input logic expB);
        logic [7:0]  mA, mB;
        logic [15:0] expIn;
        exp_t        e;
        mA        = 8'ha5 ^ {4'h0, aI};
        mB        = 8'h3c ^ {6'h0, bI};
        aValid    = aV;
        aIdx      = aI;
        aData     = {mA, aX ^ mA};
        bValid    = bV;
        bIdx      = bI;
        bData     = {mB, bX ^ mB};
        randValid = rV;
        expIn     = expA ? aData : (expB ? bData : 16'h0000);
        @(negedge clk);
        checkOutput("aReady", {31'd0, aReady}, {31'd0, expA});
        checkOutput("bReady", {31'd0, bReady}, {31'd0, expB});
        checkOutput("randReady", {31'd0, randReady}, {31'd0, expA | expB});
        if (expA || expB) begin
            e.owner = expB;
            e.idx   = expB ? {2'b00, bI} : aI;
            e.data  = expB ? bY : aY;
            e.due   = cyc + 5;
            sbQ.push_back(e);
            expCnt  = expCnt + 16'd1;
        end
        @(posedge clk);
        #1;
        checkOutput("sboxIn", {16'd0, sboxIn}, {16'd0, expIn});
        checkOutput("issueCnt", {16'd0, issueCnt}, {16'd0, expCnt});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Reset for n cycles with the given request inputs; in-flight bytes are dropped.
    task automatic applyReset(input int n, input logic aV, input logic bV, input logic rV);
        sbQ.delete();
        expCnt    = 16'd0;
        rst       = 1'b1;
        aValid    = aV;
        aIdx      = 4'h1;
        aData     = 16'h1234;
        bValid    = bV;
        bIdx      = 2'h1;
        bData     = 16'h5678;
        randValid = rV;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("rstAReady", {31'd0, aReady}, 32'd0);
            checkOutput("rstBReady", {31'd0, bReady}, 32'd0);
            checkOutput("rstRandReady", {31'd0, randReady}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput("rstSboxIn", {16'd0, sboxIn}, 32'd0);
            checkOutput("rstBusy", {31'd0, busy}, 32'd0);
            checkOutput("rstIssueCnt", {16'd0, issueCnt}, 32'd0);
        end
        rst = 1'b0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] row0 [16];
        logic [7:0] cAX [4];
        logic [7:0] cAY [4];
        logic [7:0] cBX [4];
        logic [7:0] cBY [4];
        int         j;
        row0 = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
        cAX  = '{8'h53, 8'h10, 8'h20, 8'hff};
        cAY  = '{8'hed, 8'hca, 8'hb7, 8'h16};
        cBX  = '{8'h00, 8'h01, 8'h02, 8'h03};
        cBY  = '{8'h63, 8'h7c, 8'h77, 8'h7b};

        // Reset with both ports and randomness asserted.
        applyReset(2, 1'b1, 1'b1, 1'b1);

        // Single stream on port A, one byte per cycle.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 8'(i), row0[i], 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
            if (i == 0) checkOutput("busyAfterIssue", {31'd0, busy}, 32'd1);
        end
        idleCycles(6);
        checkOutput("cntAfterStream", {16'd0, issueCnt}, 32'd16);
        checkOutput("busyIdle", {31'd0, busy}, 32'd0);

        // Contention: grants alternate A, B, A, B ...
        for (int k = 0; k < 8; k++) begin
            j = k / 2;
            if ((k % 2) == 0)
                applyStimulus(1'b1, 4'(12 + j), cAX[j], cAY[j], 1'b1, 2'(j), cBX[j], cBY[j],
                              1'b1, 1'b1, 1'b0);
            else
                applyStimulus(1'b1, 4'(12 + ((j + 1) % 4)), cAX[(j + 1) % 4], cAY[(j + 1) % 4],
                              1'b1, 2'(j), cBX[j], cBY[j], 1'b1, 1'b0, 1'b1);
        end
        idleCycles(6);

        // Randomness starvation: rand pattern 1, 0, 0, 1.
        applyStimulus(1'b1, 4'h5, 8'h05, 8'h6b, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h6, 8'h06, 8'h6f, 1'b0, 2'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 8'h06, 8'h6f, 1'b0, 2'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 8'h06, 8'h6f, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idleCycles(7);
        checkOutput("starveDrained", sbQ.size(), 32'd0);

        // Reset mid-flight: pointer moves to B, three bytes in flight, then reset.
        applyStimulus(1'b1, 4'h1, 8'h01, 8'h7c, 1'b1, 2'h2, 8'h02, 8'h77, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h2, 8'h02, 8'h77, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h3, 8'h03, 8'h7b, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idleCycles(1);
        applyReset(1, 1'b1, 1'b1, 1'b1);
        checkOutput("busyAfterRst", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 4'h4, 8'h04, 8'hf2, 1'b1, 2'h1, 8'h01, 8'h7c, 1'b1, 1'b1, 1'b0);
        idleCycles(8);

        // Counter wrap: 65535 unchecked issues, then two checked ones.
        applyReset(1, 1'b0, 1'b0, 1'b1);
        monitorEn = 1'b0;
        aValid    = 1'b1;
        aIdx      = 4'h0;
        aData     = 16'h0000;
        randValid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        aValid = 1'b0;
        checkOutput("cntFull", {16'd0, issueCnt}, 32'h0000_ffff);
        repeat (8) @(posedge clk);
        #1;
        monitorEn = 1'b1;
        expCnt    = 16'hffff;
        applyStimulus(1'b1, 4'h0, 8'h00, 8'h63, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("cntWrapZero", {16'd0, issueCnt}, 32'd0);
        applyStimulus(1'b1, 4'hf, 8'h53, 8'hed, 1'b0, 2'h0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("cntWrapOne", {16'd0, issueCnt}, 32'd1);

        // Bounded drain of remaining results.
        idleCycles(1);
        for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("finalDrain", sbQ.size(), 32'd0);
        checkOutput("finalBusy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
